audio_rec_ctrl: RTL and testbench
=================================

Name: audio_rec_ctrl

Overview:
- Record/playback sequencer for the PDM audio path.
- Gates the PDM deserializer's enable and writes each completed 16-bit word into a single-port sample RAM at an incrementing address.
- Later replays the stored words at a fixed word rate to the audio output stage.
- Sits between the button debouncers, the deserializer and the sample BRAM in the top module.

Parameters:
- ADDR_W, 14, sample RAM address width; capacity MAX_WORDS = 2**ADDR_W.
- PLAY_DIV, 16, clock cycles between playback word reads; matches the deserializer word rate. Must be >= 3.

Ports:
- clock  in  1  system clock, the same 1 MHz scaled clock that drives the deserializer.
- reset  in  1  asynchronous, active-high reset.
- record_i  in  1  single-cycle pulse; start recording.
- play_i  in  1  single-cycle pulse; start playback.
- stop_i  in  1  single-cycle pulse; abort the current operation.
- deser_done_i  in  1  word-complete strobe from the deserializer.
- deser_data_i  in  16  deserialized word; valid while deser_done_i=1.
- deser_enable_o  out  1  enable to the deserializer.
- mem_addr_o  out  ADDR_W  RAM address, shared by reads and writes.
- mem_we_o  out  1  RAM write strobe.
- mem_wdata_o  out  16  RAM write data.
- mem_re_o  out  1  RAM read strobe.
- mem_rdata_i  in  16  RAM read data, valid 1 cycle after mem_re_o.
- sample_o  out  16  playback sample, held between updates.
- sample_valid_o  out  1  1-cycle pulse when sample_o updates.
- rec_len_o  out  ADDR_W+1  number of words in the last completed recording.
- state_o  out  2  current state: 0=IDLE, 1=REC, 2=PLAY.

Behaviour:
- Reset: all outputs and internal registers are cleared.
  - state=IDLE; rec_len_o=0; addresses=0; sample_o=0.
  - mem_we_o, mem_re_o, sample_valid_o and deser_enable_o are 0.
- All outputs are registered.
- IDLE:
  - deser_enable_o=0.
  - record_i → REC, write pointer cleared to 0.
  - play_i with rec_len_o≠0 → PLAY, read pointer cleared to 0, divider cleared.
  - play_i with rec_len_o=0 is ignored.
  - record_i and play_i in the same cycle: record wins.
  - stop_i is ignored.
- REC:
  - deser_enable_o=1 from the cycle after entry.
  - On deser_done_i, the next cycle has mem_we_o=1, mem_addr_o=wptr, mem_wdata_o=deser_data_i; wptr increments. Write latency is exactly 1 cycle.
  - record_i and play_i are ignored.
  - Full: the write at address MAX_WORDS-1 sets rec_len_o=MAX_WORDS, then → IDLE and deser_enable_o drops in the same cycle as that write. No wrap and no overwrite.
  - stop_i: rec_len_o=words written, → IDLE.
    - stop_i coinciding with deser_done_i: that word is still written and counted.
- PLAY:
  - The divider counts 0..PLAY_DIV-1. At count 0, mem_re_o=1 with mem_addr_o=rptr.
  - One cycle after mem_re_o, sample_o<=mem_rdata_i and sample_valid_o=1.
  - rptr increments after each read.
  - After the read of address rec_len_o-1, its sample is delivered, then → IDLE on the following cycle.
  - stop_i → IDLE next cycle. An in-flight read's sample_valid_o is suppressed. sample_o holds its last value.
  - record_i during PLAY is ignored; stop must come first.
- mem_we_o and mem_re_o are never asserted together.
- mem_addr_o holds its last value when idle.
- rec_len_o updates only on REC exit. It is unchanged by PLAY and reset-to-0 only by reset.
- Reset mid-operation: immediate return to IDLE, outputs as at reset. A partially recorded length is lost (rec_len_o=0).

Optional Feature:
- Macro: LOOP_PLAY_EN.
- Defined: in PLAY, after the read of rec_len_o-1, rptr wraps to 0 and playback continues indefinitely at the same PLAY_DIV cadence until stop_i or reset.
- Undefined: single-shot playback as specified above.

Test Plan:
- All scenarios use ADDR_W=3, PLAY_DIV=4.
- Reset asserted mid-REC after 3 words → all outputs 0, state_o=0, rec_len_o=0; subsequent play_i ignored.
- record_i, then 5 deser_done_i strobes with data 0x1111..0x5555, then stop_i → writes to addresses 0..4, each 1 cycle after its strobe; rec_len_o=5; state_o returns to 0.
- record_i, then 10 strobes → exactly 8 writes (addresses 0..7), auto-return to IDLE after the 8th, rec_len_o=8, deser_enable_o=0, strobes 9-10 ignored.
- After the 5-word recording, play_i with RAM model → sample_valid_o pulses every 4 cycles with 0x1111..0x5555, then IDLE; 5 pulses total.
- stop_i coincident with deser_done_i (data 0xABCD) as the 3rd word → 0xABCD written at address 2, rec_len_o=3. Then play_i + stop_i one cycle after the 2nd mem_re_o → only 1 sample_valid_o pulse.
- With LOOP_PLAY_EN and rec_len_o=3 → read addresses 0,1,2,0,1,2,… continue until stop_i.

Source files
------------

// File: rtl/audio_rec_ctrl.sv
// audio_rec_ctrl: record/playback sequencer for the PDM audio path.
// Record: gates the deserializer and writes each completed word to the sample
// RAM at an incrementing address until stop or the RAM is full.
// Play: reads the stored words back one every PLAY_DIV cycles and presents
// them on sample_o with a one-cycle sample_valid_o pulse.
// Optional macro LOOP_PLAY_EN: playback wraps to address 0 after the last
// recorded word and keeps going until stop_i or reset.
module audio_rec_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int PLAY_DIV = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              record_i,
  input  logic              play_i,
  input  logic              stop_i,
  input  logic              deser_done_i,
  input  logic [15:0]       deser_data_i,
  output logic              deser_enable_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [15:0]       mem_wdata_o,
  output logic              mem_re_o,
  input  logic [15:0]       mem_rdata_i,
  output logic [15:0]       sample_o,
  output logic              sample_valid_o,
  output logic [ADDR_W:0]   rec_len_o,
  output logic [1:0]        state_o
);

  localparam int MAX_WORDS = 2**ADDR_W;
  localparam int DIV_W     = (PLAY_DIV > 1) ? $clog2(PLAY_DIV) : 1;
  localparam logic [ADDR_W:0]  LAST_WPTR = (ADDR_W+1)'(MAX_WORDS-1);
  localparam logic [ADDR_W:0]  FULL_LEN  = (ADDR_W+1)'(MAX_WORDS);
  localparam logic [ADDR_W:0]  ONE       = (ADDR_W+1)'(1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PLAY_DIV-1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W:0]   wptr;     // words written so far in this recording
  logic [ADDR_W:0]   rptr;     // next playback address
  logic [DIV_W-1:0]  div;      // playback cadence counter
  logic              rd_d1;    // RAM data for the last read is valid this cycle
  logic              last_rd;  // final word of a single-shot playback issued

  assign state_o = state;

  // Sequencer: mode control, RAM strobes and playback pipeline, all registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      wptr           <= '0;
      rptr           <= '0;
      div            <= '0;
      rd_d1          <= 1'b0;
      last_rd        <= 1'b0;
      deser_enable_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_we_o       <= 1'b0;
      mem_wdata_o    <= '0;
      mem_re_o       <= 1'b0;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      rec_len_o      <= '0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      mem_we_o       <= 1'b0;
      mem_re_o       <= 1'b0;
      sample_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          deser_enable_o <= 1'b0;
          rd_d1          <= 1'b0;
          if (record_i) begin
            state          <= S_REC;
            wptr           <= '0;
            deser_enable_o <= 1'b1;
          end else if (play_i && rec_len_o != '0) begin
            state   <= S_PLAY;
            rptr    <= '0;
            div     <= '0;
            last_rd <= 1'b0;
          end
        end
        S_REC: begin
          if (deser_done_i) begin
            mem_we_o    <= 1'b1;
            mem_addr_o  <= wptr[ADDR_W-1:0];
            mem_wdata_o <= deser_data_i;
            wptr        <= wptr + ONE;
          end
          // a full RAM ends the recording on the write of the last slot
          if (deser_done_i && wptr == LAST_WPTR) begin
            rec_len_o      <= FULL_LEN;
            state          <= S_IDLE;
            deser_enable_o <= 1'b0;
          end else if (stop_i) begin
            // a word completing alongside stop is still kept
            rec_len_o      <= wptr + (ADDR_W+1)'(deser_done_i);
            state          <= S_IDLE;
            deser_enable_o <= 1'b0;
          end
        end
        S_PLAY: begin
          if (stop_i) begin
            // drop any read still in flight; sample_o keeps its old value
            state <= S_IDLE;
            rd_d1 <= 1'b0;
          end else begin
            rd_d1 <= mem_re_o;
            if (rd_d1) begin
              sample_o       <= mem_rdata_i;
              sample_valid_o <= 1'b1;
            end
            if (sample_valid_o && last_rd)
              state <= S_IDLE;
            div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            if (div == '0 && !last_rd) begin
              mem_re_o   <= 1'b1;
              mem_addr_o <= rptr[ADDR_W-1:0];
              if (rptr == rec_len_o - ONE) begin
`ifdef LOOP_PLAY_EN
                rptr <= '0;
`else
                rptr    <= rptr + ONE;
                last_rd <= 1'b1;
`endif
              end else begin
                rptr <= rptr + ONE;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_rec_ctrl.sv
// Self-checking bench for audio_rec_ctrl (ADDR_W=3, PLAY_DIV=4).
// Honours LOOP_PLAY_EN for the final playback scenario.
module tb_audio_rec_ctrl;
  localparam int AW = 3;
  localparam int PD = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          record_i = 1'b0, play_i = 1'b0, stop_i = 1'b0, deser_done_i = 1'b0;
  logic [15:0]   deser_data_i = '0;
  logic          deser_enable_o, mem_we_o, mem_re_o, sample_valid_o;
  logic [AW-1:0] mem_addr_o;
  logic [15:0]   mem_wdata_o, mem_rdata_i, sample_o;
  logic [AW:0]   rec_len_o;
  logic [1:0]    state_o;

  audio_rec_ctrl #(.ADDR_W(AW), .PLAY_DIV(PD)) dut (
    .clock(clock), .reset(reset), .record_i(record_i), .play_i(play_i),
    .stop_i(stop_i), .deser_done_i(deser_done_i), .deser_data_i(deser_data_i),
    .deser_enable_o(deser_enable_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i),
    .sample_o(sample_o), .sample_valid_o(sample_valid_o), .rec_len_o(rec_len_o),
    .state_o(state_o)
  );

  always #5 clock = ~clock;

  // sample RAM model: synchronous write, read data valid the cycle after mem_re_o
  logic [15:0] ram [8];
  initial mem_rdata_i = '0;
  always @(posedge clock) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= ram[mem_addr_o];
  end

  // monitor: logs RAM traffic and sample pulses mid-cycle
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  logic [15:0] wr_a[$], wr_d[$], wr_s[$], re_a[$], sv_d[$];
  int sv_t[$];
  int both_cnt = 0;
  always @(negedge clock) begin
    if (mem_we_o) begin
      wr_a.push_back(16'(mem_addr_o)); wr_d.push_back(mem_wdata_o);
      wr_s.push_back({13'd0, state_o, deser_enable_o});
    end
    if (mem_re_o) re_a.push_back(16'(mem_addr_o));
    if (sample_valid_o) begin sv_d.push_back(sample_o); sv_t.push_back(cyc); end
    if (mem_we_o && mem_re_o) both_cnt++;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clr_q();
    wr_a.delete(); wr_d.delete(); wr_s.delete(); re_a.delete(); sv_d.delete(); sv_t.delete();
  endtask

  task automatic cmd(input logic r, input logic p, input logic s);
    @(negedge clock); record_i = r; play_i = p; stop_i = s;
    @(negedge clock); record_i = 0; play_i = 0; stop_i = 0;
  endtask

  task automatic strobe(input logic [15:0] d);
    @(negedge clock); deser_done_i = 1; deser_data_i = d;
    @(negedge clock); deser_done_i = 0;
  endtask

  function automatic logic [15:0] qget(input logic [15:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 16'hDEAD;
  endfunction

  typedef struct {
    logic rec, play, stop, done;
    logic [15:0] data;
    logic [1:0] st; logic en, we; logic [2:0] addr; logic [15:0] wd; logic [3:0] len;
  } vec_t;
  vec_t tv[9];

  initial begin
    int nre, idle_t;
    // 5-word recording, one vector per clock; outputs are those after the edge
    tv[0] = '{0,0,1,0,16'h0000, 2'd0,0,0,3'd0,16'h0000,4'd0}; // stop in IDLE ignored
    tv[1] = '{1,0,0,0,16'h0000, 2'd1,1,0,3'd0,16'h0000,4'd0};
    tv[2] = '{0,0,0,1,16'h1111, 2'd1,1,1,3'd0,16'h1111,4'd0};
    tv[3] = '{1,0,0,0,16'h0000, 2'd1,1,0,3'd0,16'h1111,4'd0}; // record ignored in REC
    tv[4] = '{0,0,0,1,16'h2222, 2'd1,1,1,3'd1,16'h2222,4'd0};
    tv[5] = '{0,1,0,1,16'h3333, 2'd1,1,1,3'd2,16'h3333,4'd0}; // play ignored in REC
    tv[6] = '{0,0,0,1,16'h4444, 2'd1,1,1,3'd3,16'h4444,4'd0};
    tv[7] = '{0,0,0,1,16'h5555, 2'd1,1,1,3'd4,16'h5555,4'd0};
    tv[8] = '{0,0,1,0,16'h0000, 2'd0,0,0,3'd4,16'h5555,4'd5};

    // ---- reset state
    repeat (3) @(posedge clock);
    @(negedge clock); reset = 0;
    chk("reset_outputs", {state_o, deser_enable_o, mem_we_o, mem_re_o, sample_valid_o,
        mem_addr_o, rec_len_o, sample_o, mem_wdata_o}, 64'd0);

    // ---- reset mid-REC after 3 words
    cmd(1, 0, 0);
    strobe(16'h0001); strobe(16'h0002); strobe(16'h0003);
    chk("midrec_state", {state_o, deser_enable_o}, {2'd1, 1'b1});
    #2 reset = 1; #1;
    chk("midrec_reset_outputs", {state_o, deser_enable_o, mem_we_o, mem_re_o, sample_valid_o,
        mem_addr_o, rec_len_o, sample_o, mem_wdata_o}, 64'd0);
    @(negedge clock); reset = 0;
    clr_q();
    cmd(0, 1, 0);
    repeat (6) @(negedge clock);
    chk("play_after_reset_ignored", {state_o, 16'(re_a.size())}, 18'd0);

    // ---- table: 5-word recording ended by stop
    clr_q();
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      record_i = tv[i].rec; play_i = tv[i].play; stop_i = tv[i].stop;
      deser_done_i = tv[i].done; deser_data_i = tv[i].data;
      @(posedge clock); #1;
      chk($sformatf("rec5_vec%0d", i),
          {state_o, deser_enable_o, mem_we_o, mem_addr_o, mem_wdata_o, rec_len_o},
          {tv[i].st, tv[i].en, tv[i].we, tv[i].addr, tv[i].wd, tv[i].len});
    end
    @(negedge clock); record_i = 0; play_i = 0; stop_i = 0; deser_done_i = 0;

    // ---- playback of the 5-word recording
    clr_q(); idle_t = -1;
    cmd(0, 1, 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
`ifdef LOOP_PLAY_EN
      if (sv_d.size() >= 5) break;
`else
      if (state_o == 2'd0) begin idle_t = cyc; break; end
`endif
    end
`ifdef LOOP_PLAY_EN
    cmd(0, 0, 1);
    repeat (2) @(negedge clock);
    chk("play5_pulses_min", 64'(sv_d.size() >= 5), 64'd1);
`else
    chk("play5_pulses", sv_d.size(), 5);
    chk("play5_idle_after_last", 64'(idle_t - ((sv_t.size() > 4) ? sv_t[4] : 0)), 64'd1);
`endif
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("play5_sample%0d", i), qget(sv_d, i), 16'h1111 * 16'(i + 1));
      chk($sformatf("play5_raddr%0d", i), qget(re_a, i), 16'(i));
    end
    for (int i = 1; i < 5; i++)
      chk($sformatf("play5_spacing%0d", i),
          64'((sv_t.size() > i) ? sv_t[i] - sv_t[i-1] : 0), 64'(PD));
    chk("play5_end_state", {state_o, rec_len_o}, {2'd0, 4'd5});

    // ---- overflow: 10 strobes, 8 writes, auto-return to IDLE
    clr_q();
    cmd(1, 0, 0);
    for (int i = 0; i < 10; i++) strobe(16'h0100 + 16'(i));
    repeat (2) @(negedge clock);
    chk("full_writes", wr_a.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("full_wr%0d", i), {qget(wr_a, i), qget(wr_d, i)},
          {16'(i), 16'h0100 + 16'(i)});
    chk("full_exit_with_last_write", qget(wr_s, 7), 16'd0);
    chk("full_end", {state_o, deser_enable_o, rec_len_o}, {2'd0, 1'b0, 4'd8});

    // ---- stop coincident with the 3rd strobe, then aborted playback
    clr_q();
    cmd(1, 0, 0);
    strobe(16'h0A01); strobe(16'h0A02);
    @(negedge clock); deser_done_i = 1; deser_data_i = 16'hABCD; stop_i = 1;
    @(negedge clock); deser_done_i = 0; stop_i = 0;
    repeat (2) @(negedge clock);
    chk("stopdone_writes", wr_a.size(), 3);
    chk("stopdone_wr2", {qget(wr_a, 2), qget(wr_d, 2)}, {16'd2, 16'hABCD});
    chk("stopdone_len", {state_o, rec_len_o}, {2'd0, 4'd3});

    clr_q(); nre = 0;
    cmd(0, 1, 0);
    for (int i = 0; i < 30 && nre < 2; i++) begin
      @(negedge clock);
      if (mem_re_o) nre++;
    end
    chk("abort_saw_two_reads", nre, 2);
    @(negedge clock); stop_i = 1;
    @(negedge clock); stop_i = 0;
    repeat (8) @(negedge clock);
    chk("abort_one_pulse", sv_d.size(), 1);
    chk("abort_sample_held", sample_o, 16'h0A01);
    chk("abort_end", {state_o, rec_len_o}, {2'd0, 4'd3});

`ifdef LOOP_PLAY_EN
    // ---- looping playback over 3 words
    clr_q();
    cmd(0, 1, 0);
    for (int i = 0; i < 60 && re_a.size() < 7; i++) @(negedge clock);
    cmd(0, 0, 1);
    repeat (4) @(negedge clock);
    for (int i = 0; i < 7; i++)
      chk($sformatf("loop_raddr%0d", i), qget(re_a, i), 16'(i % 3));
    chk("loop_stopped", state_o, 2'd0);
`else
    // ---- single-shot replay of the 3-word recording
    clr_q();
    cmd(0, 1, 0);
    for (int i = 0; i < 40 && state_o != 2'd0; i++) @(negedge clock);
    chk("replay3_pulses", sv_d.size(), 3);
    chk("replay3_s0", qget(sv_d, 0), 16'h0A01);
    chk("replay3_s1", qget(sv_d, 1), 16'h0A02);
    chk("replay3_s2", qget(sv_d, 2), 16'hABCD);
    chk("replay3_end", state_o, 2'd0);
`endif

    chk("never_we_and_re", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
